mcs4_clock_gen: RTL and testbench



---
 rtl/mcs4_clock_gen.sv | 147 ++++++++++++++
 tb/tb_mcs4_clock_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mcs4_clock_gen.sv
// MCS-4 two-phase clock / SYNC / power-on-clear generator.
// The optional single-step halt logic is built when MCS4_STEP_EN is defined.
// All outputs come straight from flops loaded with next-state decodes.
module mcs4_clock_gen #(
    parameter int unsigned CLK1_LEN   = 2,
    parameter int unsigned GAP1_LEN   = 1,
    parameter int unsigned CLK2_LEN   = 2,
    parameter int unsigned GAP2_LEN   = 1,
    parameter int unsigned POC_CYCLES = 2
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       poc_req,
`ifdef MCS4_STEP_EN
    input  logic       step_mode,
    input  logic       step_req,
    output logic       halted,
`endif
    output logic       clk1_pad,
    output logic       clk2_pad,
    output logic       sync_pad,
    output logic       poc_pad,
    output logic [2:0] phase,
    output logic       cycle_start
);

    localparam logic [7:0] L0_LAST = 8'(CLK1_LEN - 1);
    localparam logic [7:0] L1_LAST = 8'(GAP1_LEN - 1);
    localparam logic [7:0] L2_LAST = 8'(CLK2_LEN - 1);
    localparam logic [7:0] L3_LAST = 8'(GAP2_LEN - 1);
    localparam logic [7:0] POC_N   = 8'(POC_CYCLES);

    // ph_q is the internal period counter; it idles at 7 (end of X3) out of
    // reset so the first edge wraps cleanly into A1, while the phase output
    // register still resets to 0.
    logic [1:0] seg_q, seg_d;
    logic [7:0] len_q, len_d;
    logic [2:0] ph_q, ph_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic       poc_q, poc_d;
    logic       clk1_q, clk1_d, clk2_q, clk2_d, sync_q, sync_d, cs_q, cs_d;
    logic [2:0] phase_q;
    logic       last, wrap, halt_now;

    // End-of-segment decode against the length of the current segment
    always_comb begin
        last = 1'b0;
        case (seg_q)
            2'd0: last = (len_q == L0_LAST);
            2'd1: last = (len_q == L1_LAST);
            2'd2: last = (len_q == L2_LAST);
            2'd3: last = (len_q == L3_LAST);
            default: last = 1'b0;
        endcase
    end

    assign wrap = last && (seg_q == 2'd3) && (ph_q == 3'd7);

`ifdef MCS4_STEP_EN
    logic step_req_q, halted_q, step_rise;

    assign step_rise = step_req && !step_req_q;
    // Park at the X3/A1 boundary while stepping, unless a step edge frees it.
    assign halt_now  = wrap && step_mode && !(halted_q && step_rise);
    assign halted    = halted_q;

    // Step request edge detector and halt flag
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            step_req_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            step_req_q <= step_req;
            halted_q   <= halt_now;
        end
    end
`else
    assign halt_now = 1'b0;
`endif

    // Next-state: segment/phase sequencing, POC counting and output decode
    always_comb begin
        seg_d  = seg_q;
        len_d  = len_q;
        ph_d   = ph_q;
        poc_d  = poc_q;
        pcnt_d = pcnt_q;
        if (!halt_now) begin
            if (last) begin
                seg_d = seg_q + 2'd1;
                len_d = '0;
                if (seg_q == 2'd3) ph_d = ph_q + 3'd1;
            end else begin
                len_d = len_q + 8'd1;
            end
        end
        cs_d = wrap && !halt_now;
        // The first A1 start after a request only arms the count, so a
        // partial cycle never counts; release on the A1 start that follows
        // POC_CYCLES complete cycles.
        if (poc_req) begin
            poc_d  = 1'b1;
            pcnt_d = '0;
        end else if (poc_q && cs_d) begin
            if (pcnt_q == POC_N) poc_d = 1'b0;
            else                 pcnt_d = pcnt_q + 8'd1;
        end
        clk1_d = (seg_d == 2'd0) && !halt_now;
        clk2_d = (seg_d == 2'd2) && !halt_now;
        sync_d = (ph_d == 3'd7) && !halt_now;
    end

    // State and output registers
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q   <= 2'd3;
            len_q   <= L3_LAST;
            ph_q    <= 3'd7;
            pcnt_q  <= '0;
            poc_q   <= 1'b1;
            clk1_q  <= 1'b0;
            clk2_q  <= 1'b0;
            sync_q  <= 1'b0;
            cs_q    <= 1'b0;
            phase_q <= 3'd0;
        end else begin
            seg_q   <= seg_d;
            len_q   <= len_d;
            ph_q    <= ph_d;
            pcnt_q  <= pcnt_d;
            poc_q   <= poc_d;
            clk1_q  <= clk1_d;
            clk2_q  <= clk2_d;
            sync_q  <= sync_d;
            cs_q    <= cs_d;
            phase_q <= ph_d;
        end
    end

    assign clk1_pad    = clk1_q;
    assign clk2_pad    = clk2_q;
    assign sync_pad    = sync_q;
    assign poc_pad     = poc_q;
    assign phase       = phase_q;
    assign cycle_start = cs_q;

endmodule

// File: tb/tb_mcs4_clock_gen.sv
// Directed bench for mcs4_clock_gen: default lengths (P=6) plus an
// all-ones instance (P=4, POC_CYCLES=1).
module tb_mcs4_clock_gen;

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       poc_req = 1'b0;
    logic       poc_req2 = 1'b0;
    logic       clk1, clk2, sync, poc, cs;
    logic [2:0] phase;
    logic       b_clk1, b_clk2, b_sync, b_poc, b_cs;
    logic [2:0] b_phase;
`ifdef MCS4_STEP_EN
    logic       step_mode = 1'b0, step_req = 1'b0, halted;
    logic       step_mode2 = 1'b0, step_req2 = 1'b0, halted2;
`endif

    int nvec = 0;
    int nerr = 0;
    int en   = 0;
    int nsync = 0;

    always #5 sysclk = ~sysclk;

    mcs4_clock_gen dut (
        .sysclk(sysclk), .reset_n(reset_n), .poc_req(poc_req),
`ifdef MCS4_STEP_EN
        .step_mode(step_mode), .step_req(step_req), .halted(halted),
`endif
        .clk1_pad(clk1), .clk2_pad(clk2), .sync_pad(sync), .poc_pad(poc),
        .phase(phase), .cycle_start(cs)
    );

    mcs4_clock_gen #(.CLK1_LEN(1), .GAP1_LEN(1), .CLK2_LEN(1), .GAP2_LEN(1),
                     .POC_CYCLES(1)) dut_b (
        .sysclk(sysclk), .reset_n(reset_n), .poc_req(poc_req2),
`ifdef MCS4_STEP_EN
        .step_mode(step_mode2), .step_req(step_req2), .halted(halted2),
`endif
        .clk1_pad(b_clk1), .clk2_pad(b_clk2), .sync_pad(b_sync), .poc_pad(b_poc),
        .phase(b_phase), .cycle_start(b_cs)
    );

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s edge %0d: got %0d exp %0d", tag, en, got, exp);
        end
    endtask

    // POC windows: reset (falls at edge 97), req at 165 (falls 289),
    // req coincident with A1 start at 337 (falls 481).
    function automatic int exp_poc(input int n);
        return int'((n < 97) || (n >= 165 && n < 289) || (n >= 337 && n < 481));
    endfunction

    // Walk edges 1..last after a reset release, checking both instances.
    task automatic run(input int last);
        for (int n = 1; n <= last; n++) begin
            int pos, ph, bp, bph;
            @(posedge sysclk); #1;
            en  = n;
            pos = (n - 1) % 6;
            ph  = ((n - 1) / 6) % 8;
            chk("clk1",  clk1,  int'(pos < 2));
            chk("clk2",  clk2,  int'(pos == 3 || pos == 4));
            chk("phase", phase, ph);
            chk("sync",  sync,  int'(ph == 7));
            chk("cs",    cs,    int'((n - 1) % 48 == 0));
            chk("poc",   poc,   exp_poc(n));
            if (n <= 144 && sync) nsync++;
            bp  = (n - 1) % 4;
            bph = ((n - 1) / 4) % 8;
            chk("b_ovl",  b_clk1 & b_clk2, 0);
            chk("b_clk1", b_clk1, int'(bp == 0));
            chk("b_clk2", b_clk2, int'(bp == 2));
            chk("b_sync", b_sync, int'(bph == 7));
            chk("b_poc",  b_poc,  int'(n < 33));
            poc_req = (n == 164 || n == 336);
        end
        poc_req = 1'b0;
    endtask

    initial begin
        #22;
        chk("rst_clk1", clk1, 0);
        chk("rst_clk2", clk2, 0);
        chk("rst_sync", sync, 0);
        chk("rst_poc",  poc,  1);
        chk("rst_ph",   phase, 0);
        chk("rst_cs",   cs,   0);
`ifdef MCS4_STEP_EN
        chk("rst_halt", halted, 0);
`endif
        @(negedge sysclk);
        reset_n = 1'b1;
        run(490);
        chk("sync_cnt", nsync, 18);

        // edge 490 sits inside clk2 high; reset must clear asynchronously
        en = 0;
        chk("mid_clk2_pre", clk2, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_clk2", clk2, 0);
        chk("mid_poc",  poc,  1);
        chk("mid_ph",   phase, 0);
        chk("mid_cs",   cs,   0);
        @(negedge sysclk);
        @(negedge sysclk);
        reset_n = 1'b1;
        run(24);

`ifdef MCS4_STEP_EN
        begin
            int c1, c2, cs1;
            logic p1, p2, ps;
            step_mode = 1'b1;
            for (int i = 0; i < 60 && !halted; i++) begin
                @(posedge sysclk); #1;
            end
            chk("halt_on",   halted, 1);
            chk("halt_ph",   phase, 7);
            chk("halt_clk1", clk1, 0);
            chk("halt_sync", sync, 0);
            repeat (5) @(posedge sysclk);
            #1;
            chk("halt_hold", halted, 1);
            step_req = 1'b1;
            c1 = 0; c2 = 0; cs1 = 0;
            p1 = clk1; p2 = clk2; ps = sync;
            for (int i = 0; i < 120; i++) begin
                @(posedge sysclk); #1;
                if (clk1 && !p1) c1++;
                if (clk2 && !p2) c2++;
                if (sync && !ps) cs1++;
                p1 = clk1; p2 = clk2; ps = sync;
                if (halted) break;
            end
            chk("step_clk1", c1, 8);
            chk("step_clk2", c2, 8);
            chk("step_sync", cs1, 1);
            chk("step_halt", halted, 1);
            step_req  = 1'b0;
            step_mode = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
